// File: rtl/cpu_trace_buffer.sv
// Circular PC/instruction/memory-traffic trace buffer with PC-match trigger, post-trigger window and oldest-first readout.
// Define TRACE_MEM_ONLY_EN to restrict capture (and triggering) to cycles with mread or mwrite set.
module cpu_trace_buffer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          arm,
  input  logic [DATA_W-1:0]             trig_pc,
  input  logic [DATA_W-1:0]             pcadd,
  input  logic [DATA_W-1:0]             ins,
  input  logic [DATA_W-1:0]             maddr,
  input  logic [DATA_W-1:0]             mdata,
  input  logic                          mread,
  input  logic                          mwrite,
  output logic                          armed,
  output logic                          triggered,
  output logic                          done,
  input  logic                          rd_en,
  output logic                          rd_valid,
  output logic [DATA_W-1:0]             rd_pc,
  output logic [DATA_W-1:0]             rd_ins,
  output logic [DATA_W-1:0]             rd_addr,
  output logic [DATA_W-1:0]             rd_data,
  output logic [1:0]                    rd_flags,
  output logic                          rd_empty,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 4 * DATA_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;

  state_t        state;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] post_cnt;
  logic [CW-1:0] unread;

  logic          sample_c;
  logic          hit_c;
  logic          wr_c;
  logic [AW-1:0] wr_ptr_nxt_c;
  logic [CW-1:0] count_nxt_c;

  // Sample qualification and next write-side pointers.
  always_comb begin
    sample_c     = 1'b0;
    hit_c        = 1'b0;
    wr_c         = 1'b0;
    wr_ptr_nxt_c = wr_ptr + AW'(1);
    count_nxt_c  = (count == CW'(DEPTH)) ? count : count + CW'(1);
`ifdef TRACE_MEM_ONLY_EN
    sample_c     = en & (mread | mwrite);
`else
    sample_c     = en;
`endif
    hit_c        = sample_c && (pcadd == trig_pc);
    wr_c         = sample_c && !arm && ((state == S_ARMED) || (state == S_POST));
  end

  // Entry storage is not reset; only the pointers qualify its contents.
  always_ff @(posedge clk) begin
    if (wr_c) mem[wr_ptr] <= {pcadd, ins, maddr, mdata, mwrite, mread};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      armed     <= 1'b0;
      triggered <= 1'b0;
      done      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      post_cnt  <= '0;
      unread    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      rd_pc     <= '0;
      rd_ins    <= '0;
      rd_addr   <= '0;
      rd_data   <= '0;
      rd_flags  <= '0;
      rd_empty  <= 1'b1;
    end else begin
      rd_valid <= 1'b0;
      if (arm) begin
        state     <= S_ARMED;
        armed     <= 1'b1;
        triggered <= 1'b0;
        done      <= 1'b0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        post_cnt  <= '0;
        unread    <= '0;
        count     <= '0;
        rd_empty  <= 1'b1;
      end else begin
        case (state)
          S_ARMED: begin
            if (wr_c) begin
              wr_ptr <= wr_ptr_nxt_c;
              count  <= count_nxt_c;
              if (hit_c) begin
                armed <= 1'b0;
                if (POST_TRIG == 0) begin
                  state    <= S_DONE;
                  done     <= 1'b1;
                  rd_ptr   <= wr_ptr_nxt_c - AW'(count_nxt_c);
                  unread   <= count_nxt_c;
                  rd_empty <= 1'b0;
                end else begin
                  state     <= S_POST;
                  triggered <= 1'b1;
                  post_cnt  <= CW'(POST_TRIG);
                end
              end
            end
          end
          S_POST: begin
            if (wr_c) begin
              wr_ptr   <= wr_ptr_nxt_c;
              count    <= count_nxt_c;
              post_cnt <= post_cnt - CW'(1);
              if (post_cnt == CW'(1)) begin
                state     <= S_DONE;
                triggered <= 1'b0;
                done      <= 1'b1;
                rd_ptr    <= wr_ptr_nxt_c - AW'(count_nxt_c);
                unread    <= count_nxt_c;
                rd_empty  <= 1'b0;
              end
            end
          end
          S_DONE: begin
            // Read pointer starts at the oldest surviving entry.
            if (rd_en && !rd_empty) begin
              rd_valid <= 1'b1;
              {rd_pc, rd_ins, rd_addr, rd_data, rd_flags} <= mem[rd_ptr];
              rd_ptr   <= rd_ptr + AW'(1);
              unread   <= unread - CW'(1);
              rd_empty <= (unread == CW'(1));
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
